// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and ALU operand selection.
// Define EXOP_FWD_EN to enable MEM/WB forwarding and the WB write-through while stalled.
module ex_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 3,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs_addr,
  input  logic [RADDR_W-1:0] id_rt_addr,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [4:0]         id_shamt,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_b_imm,
  input  logic               id_shift_imm,
  input  logic               id_shift_var,
  input  logic [RADDR_W-1:0] id_wr_addr,
  input  logic               id_wr_en,
  input  logic               mem_wr_en,
  input  logic [RADDR_W-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0]  mem_wr_data,
  input  logic               wb_wr_en,
  input  logic [RADDR_W-1:0] wb_wr_addr,
  input  logic [DATA_W-1:0]  wb_wr_data,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic [RADDR_W-1:0] ex_wr_addr,
  output logic               ex_wr_en,
  output logic               ex_valid
);

  logic               valid_q;
  logic [RADDR_W-1:0] rs_addr_q, rt_addr_q, wr_addr_q;
  logic [DATA_W-1:0]  rs_data_q, rt_data_q, imm_q;
  logic [4:0]         shamt_q;
  logic [ALUOP_W-1:0] alu_op_q;
  logic               b_imm_q, shift_imm_q, shift_var_q, wr_en_q;
  logic [DATA_W-1:0]  fwd_rs, fwd_rt;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q     <= 1'b0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      alu_op_q    <= '0;
      b_imm_q     <= 1'b0;
      shift_imm_q <= 1'b0;
      shift_var_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_en_q     <= 1'b0;
    end else if (stall) begin
`ifdef EXOP_FWD_EN
      // A result retiring from WB while we hold would otherwise never be seen again.
      if (wb_wr_en && (wb_wr_addr != '0) && (wb_wr_addr == rs_addr_q)) rs_data_q <= wb_wr_data;
      if (wb_wr_en && (wb_wr_addr != '0) && (wb_wr_addr == rt_addr_q)) rt_data_q <= wb_wr_data;
`endif
    end else begin
      valid_q     <= id_valid;
      rs_addr_q   <= id_rs_addr;
      rt_addr_q   <= id_rt_addr;
      rs_data_q   <= id_rs_data;
      rt_data_q   <= id_rt_data;
      imm_q       <= id_imm;
      shamt_q     <= id_shamt;
      alu_op_q    <= id_alu_op;
      b_imm_q     <= id_b_imm;
      shift_imm_q <= id_shift_imm;
      shift_var_q <= id_shift_var;
      wr_addr_q   <= id_wr_addr;
      wr_en_q     <= id_wr_en;
    end
  end

`ifdef EXOP_FWD_EN
  always_comb begin
    fwd_rs = rs_data_q;
    if (mem_wr_en && (mem_wr_addr == rs_addr_q) && (rs_addr_q != '0))   fwd_rs = mem_wr_data;
    else if (wb_wr_en && (wb_wr_addr == rs_addr_q) && (rs_addr_q != '0)) fwd_rs = wb_wr_data;
    fwd_rt = rt_data_q;
    if (mem_wr_en && (mem_wr_addr == rt_addr_q) && (rt_addr_q != '0))   fwd_rt = mem_wr_data;
    else if (wb_wr_en && (wb_wr_addr == rt_addr_q) && (rt_addr_q != '0)) fwd_rt = wb_wr_data;
  end
`else
  assign fwd_rs = rs_data_q;
  assign fwd_rt = rt_data_q;
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{mem_wr_en, mem_wr_addr, mem_wr_data, wb_wr_en, wb_wr_addr,
                               wb_wr_data, rs_addr_q, rt_addr_q};
`endif

  // Shift amounts are masked to 5 bits so the ALU never sees more than 31.
  always_comb begin
    alu_a = fwd_rs;
    alu_b = fwd_rt;
    if (shift_imm_q) begin
      alu_a = fwd_rt;
      alu_b = {{(DATA_W-5){1'b0}}, shamt_q};
    end else if (shift_var_q) begin
      alu_a = fwd_rt;
      alu_b = {{(DATA_W-5){1'b0}}, fwd_rs[4:0]};
    end else if (b_imm_q) begin
      alu_b = imm_q;
    end
  end

  assign alu_op        = alu_op_q;
  assign ex_store_data = fwd_rt;
  assign ex_wr_addr    = wr_addr_q;
  assign ex_wr_en      = wr_en_q & valid_q;
  assign ex_valid      = valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed scenarios then random traffic,
// checked against a transaction-level model of the instruction held in EX.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_wr_addr, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [2:0]  id_alu_op;
  logic        id_b_imm, id_shift_imm, id_shift_var, id_wr_en;
  logic        mem_wr_en, wb_wr_en;
  logic [4:0]  mem_wr_addr, wb_wr_addr;
  logic [31:0] mem_wr_data, wb_wr_data;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_op;
  logic [4:0]  ex_wr_addr;
  logic        ex_wr_en, ex_valid;

  int checks = 0;
  int errors = 0;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt), .id_alu_op(id_alu_op),
    .id_b_imm(id_b_imm), .id_shift_imm(id_shift_imm), .id_shift_var(id_shift_var),
    .id_wr_addr(id_wr_addr), .id_wr_en(id_wr_en),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
    .ex_wr_addr(ex_wr_addr), .ex_wr_en(ex_wr_en), .ex_valid(ex_valid)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // The instruction the model believes is sitting in EX.
  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, wr_addr, shamt;
    logic [31:0] rs_val, rt_val, imm;
    logic [2:0]  op;
    logic        b_imm, sh_imm, sh_var, wr_en;
  } instr_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] store;
    logic [4:0]  wr_addr;
    logic        wr_en;
    logic        valid;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];
  instr_t held;

  function automatic instr_t bubble();
    instr_t b;
    b = '{valid: 1'b0, rs: '0, rt: '0, wr_addr: '0, shamt: '0, rs_val: '0, rt_val: '0,
          imm: '0, op: '0, b_imm: 1'b0, sh_imm: 1'b0, sh_var: 1'b0, wr_en: 1'b0};
    return b;
  endfunction

  // Value a source register really has right now: youngest in-flight producer wins.
  function automatic logic [31:0] source_value(input logic [4:0] r, input logic [31:0] v);
`ifdef EXOP_FWD_EN
    if (r == 5'd0) return v;
    if (mem_wr_en && mem_wr_addr == r) return mem_wr_data;
    if (wb_wr_en && wb_wr_addr == r) return wb_wr_data;
`endif
    return v;
  endfunction

  function automatic exp_t expected(input instr_t h);
    exp_t e;
    logic [31:0] s, t;
    s = source_value(h.rs, h.rs_val);
    t = source_value(h.rt, h.rt_val);
    if (h.sh_imm)      begin e.a = t; e.b = 32'(h.shamt); end
    else if (h.sh_var) begin e.a = t; e.b = s % 32; end
    else if (h.b_imm)  begin e.a = s; e.b = h.imm; end
    else               begin e.a = s; e.b = t; end
    e.op = h.op;
    e.store = t;
    e.wr_addr = h.wr_addr;
    e.wr_en = h.wr_en && h.valid;
    e.valid = h.valid;
    return e;
  endfunction

  function automatic instr_t next_held(input instr_t h);
    instr_t n;
    if (reset || flush) return bubble();
    if (stall) begin
      n = h;
`ifdef EXOP_FWD_EN
      if (wb_wr_en && wb_wr_addr != 0 && wb_wr_addr == h.rs) n.rs_val = wb_wr_data;
      if (wb_wr_en && wb_wr_addr != 0 && wb_wr_addr == h.rt) n.rt_val = wb_wr_data;
`endif
      return n;
    end
    n = '{valid: id_valid, rs: id_rs_addr, rt: id_rt_addr, wr_addr: id_wr_addr,
          shamt: id_shamt, rs_val: id_rs_data, rt_val: id_rt_data, imm: id_imm,
          op: id_alu_op, b_imm: id_b_imm, sh_imm: id_shift_imm, sh_var: id_shift_var,
          wr_en: id_wr_en};
    return n;
  endfunction

  // driver tasks
  task automatic set_idle();
    reset = 0; stall = 0; flush = 0; id_valid = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_shamt = 0; id_alu_op = 0; id_b_imm = 0; id_shift_imm = 0; id_shift_var = 0;
    id_wr_addr = 0; id_wr_en = 0;
    mem_wr_en = 0; mem_wr_addr = 0; mem_wr_data = 0;
    wb_wr_en = 0; wb_wr_addr = 0; wb_wr_data = 0;
  endtask

  task automatic load(input logic [4:0] rs, input logic [31:0] rs_v, input logic [4:0] rt,
                      input logic [31:0] rt_v, input logic [2:0] op, input logic wr_en);
    id_valid = 1; id_rs_addr = rs; id_rs_data = rs_v; id_rt_addr = rt; id_rt_data = rt_v;
    id_alu_op = op; id_wr_addr = 5'd9; id_wr_en = wr_en;
  endtask

  // Issue the current inputs for one cycle: predict this cycle's outputs, then advance.
  task automatic cycle();
    instr_t n;
    exp_q.push_back(EXP_W'(expected(held)));
    n = next_held(held);
    @(posedge clk);
    held = n;
    #1;
  endtask

  task automatic randomize_inputs();
    reset = ($urandom_range(0, 40) == 0);
    flush = ($urandom_range(0, 12) == 0);
    stall = ($urandom_range(0, 3) == 0);
    id_valid = 1'($urandom);
    id_rs_addr = 5'($urandom_range(0, 5)); id_rt_addr = 5'($urandom_range(0, 5));
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_shamt = 5'($urandom); id_alu_op = 3'($urandom);
    id_b_imm = 1'($urandom); id_shift_imm = ($urandom_range(0, 4) == 0);
    id_shift_var = ($urandom_range(0, 4) == 0);
    id_wr_addr = 5'($urandom); id_wr_en = 1'($urandom);
    mem_wr_en = 1'($urandom); mem_wr_addr = 5'($urandom_range(0, 5)); mem_wr_data = $urandom;
    wb_wr_en = 1'($urandom); wb_wr_addr = 5'($urandom_range(0, 5)); wb_wr_data = $urandom;
  endtask

  // scoreboard monitor
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      chk("alu_a", alu_a, e.a);
      chk("alu_b", alu_b, e.b);
      chk("alu_op", 32'(alu_op), 32'(e.op));
      chk("ex_store_data", ex_store_data, e.store);
      chk("ex_wr_addr", 32'(ex_wr_addr), 32'(e.wr_addr));
      chk("ex_wr_en", 32'(ex_wr_en), 32'(e.wr_en));
      chk("ex_valid", 32'(ex_valid), 32'(e.valid));
    end
  end

  initial begin
    set_idle();
    reset = 1;
    held = bubble();
    @(posedge clk); #1;
    cycle();                      // reset state observed, reset still high
    reset = 0;
    // add $1=5, $2=7
    load(5'd1, 32'd5, 5'd2, 32'd7, 3'b000, 1'b1); cycle();
    set_idle(); cycle();
    // forwarding priority on rs=$3 holding 1
    load(5'd3, 32'd1, 5'd4, 32'd2, 3'b001, 1'b1); cycle();
    set_idle(); stall = 1;
    mem_wr_en = 1; mem_wr_addr = 5'd3; mem_wr_data = 32'h10;
    wb_wr_en = 1; wb_wr_addr = 5'd3; wb_wr_data = 32'h20; cycle();
    mem_wr_en = 0; stall = 0; id_valid = 0; cycle();
    load(5'd0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b0); cycle();
    set_idle(); mem_wr_en = 1; mem_wr_addr = 5'd0; mem_wr_data = 32'd9; cycle();
    // sll and srav
    set_idle(); load(5'd0, 32'd0, 5'd2, 32'h8000_0000, 3'b101, 1'b1);
    id_shift_imm = 1; id_shamt = 5'd4; cycle();
    set_idle(); load(5'd5, 32'hFFFF_FF23, 5'd6, 32'h8000_0000, 3'b110, 1'b1);
    id_shift_var = 1; cycle();
    // stall write-through on rt=$4
    set_idle(); load(5'd1, 32'd3, 5'd4, 32'd1, 3'b000, 1'b1); cycle();
    set_idle(); stall = 1; wb_wr_en = 1; wb_wr_addr = 5'd4; wb_wr_data = 32'hABCD; cycle();
    set_idle(); stall = 1; cycle();
    set_idle(); cycle();
    // flush beats stall, reset mid-stall
    load(5'd1, 32'd5, 5'd2, 32'd7, 3'b010, 1'b1); cycle();
    set_idle(); flush = 1; stall = 1; cycle();
    set_idle(); load(5'd1, 32'd5, 5'd2, 32'd7, 3'b011, 1'b1); cycle();
    set_idle(); stall = 1; cycle();
    reset = 1; cycle();
    set_idle(); cycle();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      cycle();
    end
    set_idle();
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
